// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - two-requester req/ack arbiter for one register-file port
// Optional build macro: REGFILE_ARB_FIXED_PRIO_EN (requester 0 always wins; default is round-robin)
module regfile_port_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          i_ck,
    input  logic          i_rstn,
    input  logic          i_req0,
    input  logic          i_rw0,
    input  logic [AW-1:0] i_addr0,
    input  logic [DW-1:0] i_wdata0,
    input  logic          i_req1,
    input  logic          i_rw1,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata1,
    output logic          o_ack0,
    output logic          o_ack1,
    output logic [DW-1:0] o_rdata,
    output logic          o_busy,
    output logic          o_sram_csn,
    output logic          o_sram_rw,
    output logic [AW-1:0] o_sram_address,
    output logic [DW-1:0] o_sram_data,
    input  logic [DW-1:0] i_sram_data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]    state;
    logic          any_req;
    logic          start;
    logic          grant_sel;
    logic          winner;
    logic          cur_rw;
    logic          sel_rw;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign any_req = i_req0 | i_req1;
    assign start   = (state == ST_IDLE) && any_req;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it is asking; requester 1 only gets idle slots
    always_comb begin
        grant_sel = ~i_req0;
    end
`else
    logic ptr;

    // Tie goes to the preferred requester; a lone requester always wins
    always_comb begin
        if (i_req0 && i_req1) begin
            grant_sel = ptr;
        end else begin
            grant_sel = i_req1;
        end
    end

    // Preference moves to the requester that lost (or did not ask) on every grant
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr <= 1'b0;
        end else if (start) begin
            ptr <= ~grant_sel;
        end
    end
`endif

    // Route the winning requester's transaction fields toward the port registers
    always_comb begin
        if (grant_sel) begin
            sel_rw    = i_rw1;
            sel_addr  = i_addr1;
            sel_wdata = i_wdata1;
        end else begin
            sel_rw    = i_rw0;
            sel_addr  = i_addr0;
            sel_wdata = i_wdata0;
        end
    end

    // Sequencer: a fixed four-cycle walk IDLE -> ACCESS -> WAIT -> DONE per transaction
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (any_req) state <= ST_ACCESS;
                ST_ACCESS: state <= ST_WAIT;
                ST_WAIT:   state <= ST_DONE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Port lines: chip select low for the single ACCESS cycle; address/data hold between transactions
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            o_sram_csn     <= 1'b1;
            o_sram_rw      <= 1'b1;
            o_sram_address <= '0;
            o_sram_data    <= '0;
        end else if (start) begin
            o_sram_csn     <= 1'b0;
            o_sram_rw      <= sel_rw;
            o_sram_address <= sel_addr;
            o_sram_data    <= sel_wdata;
        end else if (state == ST_ACCESS) begin
            o_sram_csn     <= 1'b1;
            o_sram_rw      <= 1'b1;
        end
    end

    // Remember who was granted and whether it was a read, since o_sram_rw is parked high after ACCESS
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            winner <= 1'b0;
            cur_rw <= 1'b1;
        end else if (start) begin
            winner <= grant_sel;
            cur_rw <= sel_rw;
        end
    end

    // Completion: single-cycle ack to the winner, read data captured in the same edge
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            o_ack0  <= 1'b0;
            o_ack1  <= 1'b0;
            o_rdata <= '0;
        end else if (state == ST_WAIT) begin
            o_ack0 <= ~winner;
            o_ack1 <= winner;
            if (cur_rw) begin
                o_rdata <= i_sram_data;
            end
        end else begin
            o_ack0 <= 1'b0;
            o_ack1 <= 1'b0;
        end
    end

    // Busy mirrors "state is not IDLE" as its own register
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            o_busy <= 1'b0;
        end else if (start) begin
            o_busy <= 1'b1;
        end else if (state == ST_DONE) begin
            o_busy <= 1'b0;
        end
    end

endmodule
